// File: rtl/bec_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bec_pkg
// Shared constants and FSM encoding for the BEC multiplier arbiter.
// Revision : 1.0
// ============================================================================
package bec_pkg;

    localparam int FIELD_M         = 163;
    localparam int DEFAULT_TIMEOUT = 255;
    localparam int WD_W            = 16;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_resp  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = c_st_idle,
        ST_ISSUE = c_st_issue,
        ST_WAIT  = c_st_wait,
        ST_RESP  = c_st_resp
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bec_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : bec_rr_pick
// Combinational round-robin picker: rotate, priority encode, unrotate.
// Revision : 1.0
// ============================================================================
module bec_rr_pick
    import bec_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     valid,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int IW = $clog2(N_REQ);
    localparam logic [IW:0] c_n = (IW+1)'(N_REQ);

    // Modular add for pointer arithmetic when N_REQ is not a power of two.
    function automatic logic [IW-1:0] f_wrap(input logic [IW:0] s);
        logic [IW:0] t;
        t = (s >= c_n) ? (s - c_n) : s;
        return t[IW-1:0];
    endfunction

    logic [N_REQ-1:0] w_rot;
    logic [IW-1:0]    w_off;
    logic             w_hit;

    always_comb begin
        w_rot = '0;
        w_off = '0;
        w_hit = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            w_rot[i] = req[f_wrap((IW+1)'(i) + {1'b0, ptr})];
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (w_rot[i] && !w_hit) begin
                w_hit = 1'b1;
                w_off = IW'(i);
            end
        end
    end

    assign valid = w_hit;
    assign idx   = f_wrap({1'b0, w_off} + {1'b0, ptr});

endmodule
`default_nettype wire

// File: rtl/bec_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bec_mul_arbiter
// Round-robin scheduler sharing one GF(2^163) multiplier, with watchdog abort.
// Revision : 1.0
// ============================================================================
module bec_mul_arbiter
    import bec_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int M       = FIELD_M,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*M-1:0]       req_a,
    input  logic [N_REQ*M-1:0]       req_b,
    output logic [N_REQ-1:0]         ack,
    output logic [N_REQ-1:0]         err,
    output logic [M-1:0]             res,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     mul_start,
    output logic [M-1:0]             mul_a,
    output logic [M-1:0]             mul_b,
    output logic                     mul_abort,
    input  logic                     mul_done,
    input  logic [M-1:0]             mul_res
);

    localparam int                IW        = $clog2(N_REQ);
    localparam logic [IW-1:0]     c_last    = IW'(N_REQ - 1);
    localparam logic [WD_W-1:0]   c_timeout = WD_W'(TIMEOUT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IW-1:0]    r_grant;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    w_pick_idx;
    logic             w_pick_valid;
    logic [M-1:0]     r_mul_a;
    logic [M-1:0]     r_mul_b;
    logic [M-1:0]     r_res;
    logic [WD_W-1:0]  r_wd;
    logic [WD_W-1:0]  w_wd_inc;
    logic             w_timeout_hit;
    logic             r_tmo;
    logic             r_abort;
    logic [M-1:0]     w_a_arr [N_REQ];
    logic [M-1:0]     w_b_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign w_a_arr[gi] = req_a[gi*M +: M];
            assign w_b_arr[gi] = req_b[gi*M +: M];
        end
    endgenerate

    bec_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    // A done arriving on the final watchdog cycle takes priority over abort.
    assign w_wd_inc      = r_wd + 1'b1;
    assign w_timeout_hit = (r_state == ST_WAIT) && !mul_done && (w_wd_inc == c_timeout);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ack         = '0;
        err         = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (mul_done || w_timeout_hit) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                ack[r_grant] = 1'b1;
                err[r_grant] = r_tmo;
                w_state_nxt  = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant <= '0;
            r_ptr   <= '0;
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_res   <= '0;
            r_wd    <= '0;
            r_tmo   <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant <= w_pick_idx;
                        r_mul_a <= w_a_arr[w_pick_idx];
                        r_mul_b <= w_b_arr[w_pick_idx];
                        r_ptr   <= (w_pick_idx == c_last) ? '0 : (w_pick_idx + 1'b1);
                    end
                end
                ST_ISSUE: begin
                    r_wd <= '0;
                end
                ST_WAIT: begin
                    if (mul_done) begin
                        r_res <= mul_res;
                    end else begin
                        r_wd <= w_wd_inc;
                        if (w_timeout_hit) begin
                            r_abort <= 1'b1;
                            r_res   <= '0;
                            r_tmo   <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    r_tmo <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign grant_id  = r_grant;
    assign mul_start = (r_state == ST_ISSUE);
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign mul_abort = r_abort;
    assign res       = r_res;

endmodule
`default_nettype wire

// File: tb/tb_bec_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bec_mul_arbiter
// Directed self-checking bench for bec_mul_arbiter (TIMEOUT 255 and 16 builds).
// Revision : 1.0
// ============================================================================
module tb_bec_mul_arbiter;

    localparam int N  = 4;
    localparam int M  = 163;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]   req   = '0;
    logic [N*M-1:0] req_a = '0;
    logic [N*M-1:0] req_b = '0;

    logic [N-1:0]  ack, err;
    logic [M-1:0]  res, mul_a, mul_b;
    logic [M-1:0]  mul_res = '0;
    logic          busy, mul_start, mul_abort, mul_done;
    logic [IW-1:0] grant_id;

    logic [N-1:0]  ack_t, err_t;
    logic [M-1:0]  res_t, mul_a_t, mul_b_t;
    logic [M-1:0]  mul_res_t = '0;
    logic          busy_t, mul_start_t, mul_abort_t, mul_done_t;
    logic [IW-1:0] grant_id_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   lat    = 163;
    int   cnt    = 0;
    logic mdl_done   = 1'b0;
    logic inj_done   = 1'b0;
    logic inj_done_t = 1'b0;

    assign mul_done   = mdl_done | inj_done;
    assign mul_done_t = inj_done_t;

    bec_mul_arbiter #(.N_REQ(N), .M(M), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .ack(ack), .err(err), .res(res), .busy(busy), .grant_id(grant_id),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_abort(mul_abort),
        .mul_done(mul_done), .mul_res(mul_res)
    );

    bec_mul_arbiter #(.N_REQ(N), .M(M), .TIMEOUT(16)) dut_t (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .ack(ack_t), .err(err_t), .res(res_t), .busy(busy_t), .grant_id(grant_id_t),
        .mul_start(mul_start_t), .mul_a(mul_a_t), .mul_b(mul_b_t), .mul_abort(mul_abort_t),
        .mul_done(mul_done_t), .mul_res(mul_res_t)
    );

    // GF(2^163) product modulo x^163 + x^7 + x^6 + x^3 + 1.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r;
        logic [M-1:0] t;
        r = '0;
        t = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) r = r ^ t;
            if (t[M-1]) t = {t[M-2:0], 1'b0} ^ 163'hC9;
            else        t = {t[M-2:0], 1'b0};
        end
        return r;
    endfunction

    // Multiplier model: done arrives 'lat' cycles after the start cycle.
    always @(negedge clk) begin
        mdl_done = 1'b0;
        if (rst) begin
            cnt = 0;
        end else if (mul_start) begin
            cnt = lat;
        end else if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                mdl_done = 1'b1;
                mul_res  = gf_mul(mul_a, mul_b);
            end
        end
    end

    task automatic set_op(input int i, input logic [M-1:0] a, input logic [M-1:0] b);
        req_a[i*M +: M] = a;
        req_b[i*M +: M] = b;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req        = '0;
        inj_done   = 1'b0;
        inj_done_t = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '1;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (ack !== 4'b0 || err !== 4'b0) begin n_fail++; $display("FAIL reset_ack_err: ack=%b err=%b want 0000/0000", ack, err); end
        n_chk++; if (res !== '0) begin n_fail++; $display("FAIL reset_res: got %h want 0", res); end
        n_chk++; if (busy !== 1'b0 || mul_start !== 1'b0 || mul_abort !== 1'b0) begin n_fail++; $display("FAIL reset_ctl: busy=%b start=%b abort=%b want 0", busy, mul_start, mul_abort); end
        n_chk++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
        n_chk++; if (mul_a !== '0 || mul_b !== '0) begin n_fail++; $display("FAIL reset_operands: a=%h b=%h want 0", mul_a, mul_b); end
        n_chk++; if (busy_t !== 1'b0 || ack_t !== 4'b0) begin n_fail++; $display("FAIL reset_dut_t: busy=%b ack=%b want 0", busy_t, ack_t); end
        req = '0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        int starts, first_start, ack_cyc;
        logic [N-1:0] ack_v, err_v;
        logic [M-1:0] res_v, exp_v;
        starts = 0; first_start = -1; ack_cyc = -1;
        ack_v = '0; err_v = '0; res_v = '0;
        exp_v = 163'd1 << 162;
        do_reset();
        lat = 163;
        set_op(2, 163'd1, 163'd1 << 162);
        req = 4'b0100;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (mul_start) begin starts++; if (first_start < 0) first_start = c; end
            if (ack != 4'b0 && ack_cyc < 0) begin
                ack_cyc = c; ack_v = ack; err_v = err; res_v = res; req = '0;
            end
            if (c == 3) set_op(2, 163'd5, 163'd7);
        end
        n_chk++; if (first_start !== 1) begin n_fail++; $display("FAIL single_start_cycle: got %0d want 1", first_start); end
        n_chk++; if (starts !== 1) begin n_fail++; $display("FAIL single_start_count: got %0d want 1", starts); end
        n_chk++; if (ack_cyc !== 165) begin n_fail++; $display("FAIL single_ack_cycle: got %0d want 165", ack_cyc); end
        n_chk++; if (ack_v !== 4'b0100) begin n_fail++; $display("FAIL single_ack: got %b want 0100", ack_v); end
        n_chk++; if (res_v !== exp_v) begin n_fail++; $display("FAIL single_res: got %h want %h", res_v, exp_v); end
        n_chk++; if (err_v !== 4'b0) begin n_fail++; $display("FAIL single_err: got %b want 0000", err_v); end
        n_chk++; if (mul_a !== 163'd1 || grant_id !== 2'd2) begin n_fail++; $display("FAIL single_capture: a=%h grant=%0d want 1/2", mul_a, grant_id); end
    endtask

    task automatic test_all_four();
        int order [4];
        logic [M-1:0] rv [4];
        logic [M-1:0] exp_r [4];
        int n_ack, starts, idle_before, bad_oh, ack4_c;
        logic busy_after, err_any;
        exp_r[0] = 163'd6; exp_r[1] = 163'd5; exp_r[2] = 163'd12; exp_r[3] = 163'd15;
        n_ack = 0; starts = 0; idle_before = 0; bad_oh = 0; ack4_c = -1;
        busy_after = 1'b1; err_any = 1'b0;
        for (int k = 0; k < 4; k++) begin order[k] = -1; rv[k] = '0; end
        do_reset();
        lat = 2;
        set_op(0, 163'd2, 163'd3); set_op(1, 163'd3, 163'd3);
        set_op(2, 163'd4, 163'd3); set_op(3, 163'd5, 163'd3);
        req = 4'b1111;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (mul_start) starts++;
            if (!busy && n_ack < 4) idle_before++;
            if (ack4_c > 0 && c == ack4_c + 1) busy_after = busy;
            if (ack != 4'b0 && n_ack < 4) begin
                if (!$onehot(ack)) bad_oh++;
                for (int k = 0; k < 4; k++) if (ack[k]) order[n_ack] = k;
                rv[n_ack] = res;
                err_any = err_any | (|err);
                req = req & ~ack;
                n_ack++;
                if (n_ack == 4) ack4_c = c;
            end
        end
        for (int k = 0; k < 4; k++) begin
            n_chk++; if (order[k] !== k) begin n_fail++; $display("FAIL all4_order[%0d]: got %0d want %0d", k, order[k], k); end
            n_chk++; if (rv[k] !== exp_r[k]) begin n_fail++; $display("FAIL all4_res[%0d]: got %h want %h", k, rv[k], exp_r[k]); end
        end
        n_chk++; if (bad_oh !== 0 || err_any !== 1'b0) begin n_fail++; $display("FAIL all4_onehot_err: bad=%0d err=%b want 0/0", bad_oh, err_any); end
        n_chk++; if (starts !== 4) begin n_fail++; $display("FAIL all4_starts: got %0d want 4", starts); end
        n_chk++; if (idle_before !== 3) begin n_fail++; $display("FAIL all4_idle_gaps: got %0d want 3", idle_before); end
        n_chk++; if (ack4_c !== 19) begin n_fail++; $display("FAIL all4_last_ack_cycle: got %0d want 19", ack4_c); end
        n_chk++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL all4_busy_after: got %b want 0", busy_after); end
    endtask

    task automatic test_back_to_back();
        int g [4];
        int p [4];
        int ack_c [4];
        logic [M-1:0] rv [4];
        int exp_g [4];
        int exp_p [4];
        int n_st, n_ack;
        logic [M-1:0] exp_r0, exp_r2;
        exp_g[0] = 0; exp_g[1] = 2; exp_g[2] = 0; exp_g[3] = 2;
        exp_p[0] = 1; exp_p[1] = 3; exp_p[2] = 1; exp_p[3] = 3;
        exp_r0 = 163'hC9;
        exp_r2 = 163'd5;
        n_st = 0; n_ack = 0;
        for (int k = 0; k < 4; k++) begin g[k] = -1; p[k] = -1; ack_c[k] = -1; rv[k] = '0; end
        do_reset();
        lat = 5;
        set_op(0, 163'd2, 163'd1 << 162);
        set_op(2, 163'd3, 163'd3);
        req = 4'b0101;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (mul_start && n_st < 4) begin g[n_st] = int'(grant_id); p[n_st] = int'(dut.r_ptr); n_st++; end
            if (ack != 4'b0 && n_ack < 4) begin
                ack_c[n_ack] = c; rv[n_ack] = res; n_ack++;
                if (n_ack == 4) req = '0;
            end
        end
        for (int k = 0; k < 4; k++) begin
            n_chk++; if (g[k] !== exp_g[k] || p[k] !== exp_p[k]) begin n_fail++; $display("FAIL b2b_grant_ptr[%0d]: grant=%0d ptr=%0d want %0d/%0d", k, g[k], p[k], exp_g[k], exp_p[k]); end
            n_chk++; if (ack_c[k] !== 7 + 8*k) begin n_fail++; $display("FAIL b2b_ack_cycle[%0d]: got %0d want %0d", k, ack_c[k], 7 + 8*k); end
            n_chk++; if (rv[k] !== ((k % 2 == 0) ? exp_r0 : exp_r2)) begin n_fail++; $display("FAIL b2b_res[%0d]: got %h", k, rv[k]); end
        end
    endtask

    task automatic test_timeout();
        int st_c [2];
        int ack_c [2];
        logic [N-1:0] ack_v [2];
        logic [N-1:0] err_v [2];
        logic [M-1:0] res_v [2];
        int n_st, n_ack, n_abort, abort_c;
        n_st = 0; n_ack = 0; n_abort = 0; abort_c = -1;
        for (int k = 0; k < 2; k++) begin st_c[k] = -1; ack_c[k] = -1; ack_v[k] = '0; err_v[k] = '0; res_v[k] = '1; end
        do_reset();
        set_op(0, 163'd7, 163'd9);
        set_op(1, 163'd3, 163'd5);
        mul_res_t = 163'h1234;
        req = 4'b0011;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (mul_start_t && n_st < 2) begin st_c[n_st] = c; n_st++; end
            if (mul_abort_t) begin n_abort++; if (abort_c < 0) abort_c = c; end
            if (ack_t != 4'b0 && n_ack < 2) begin
                ack_c[n_ack] = c; ack_v[n_ack] = ack_t; err_v[n_ack] = err_t; res_v[n_ack] = res_t;
                req = req & ~ack_t;
                n_ack++;
            end
            inj_done_t = (c == 23);
        end
        inj_done_t = 1'b0;
        n_chk++; if (st_c[0] !== 1 || st_c[1] !== 20) begin n_fail++; $display("FAIL to_start_cycles: got %0d,%0d want 1,20", st_c[0], st_c[1]); end
        n_chk++; if (abort_c !== 18 || n_abort !== 1) begin n_fail++; $display("FAIL to_abort: cycle=%0d count=%0d want 18/1", abort_c, n_abort); end
        n_chk++; if (ack_c[0] !== 18 || ack_v[0] !== 4'b0001 || err_v[0] !== 4'b0001) begin n_fail++; $display("FAIL to_ack_err: cyc=%0d ack=%b err=%b want 18/0001/0001", ack_c[0], ack_v[0], err_v[0]); end
        n_chk++; if (res_v[0] !== '0) begin n_fail++; $display("FAIL to_res_zero: got %h want 0", res_v[0]); end
        n_chk++; if (ack_c[1] !== 24 || ack_v[1] !== 4'b0010 || err_v[1] !== 4'b0) begin n_fail++; $display("FAIL to_next_ack: cyc=%0d ack=%b err=%b want 24/0010/0000", ack_c[1], ack_v[1], err_v[1]); end
        n_chk++; if (res_v[1] !== 163'h1234) begin n_fail++; $display("FAIL to_next_res: got %h want 1234", res_v[1]); end
    endtask

    task automatic test_spurious_done();
        int n_ack, ack_c, n_abort;
        logic [N-1:0] ack_v, err_v;
        logic [M-1:0] res_v;
        n_ack = 0; ack_c = -1; n_abort = 0;
        ack_v = '0; err_v = '0; res_v = '0;
        do_reset();
        mul_res_t = 163'h55;
        inj_done_t = 1'b1;
        @(negedge clk);
        inj_done_t = 1'b0;
        @(negedge clk);
        n_chk++; if (ack_t !== 4'b0 || busy_t !== 1'b0) begin n_fail++; $display("FAIL spur_idle_noreq: ack=%b busy=%b want 0000/0", ack_t, busy_t); end
        set_op(3, 163'd1, 163'd1);
        req = 4'b1000;
        inj_done_t = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (ack_t != 4'b0) begin
                n_ack++;
                if (ack_c < 0) begin ack_c = c; ack_v = ack_t; err_v = err_t; res_v = res_t; req = '0; end
            end
            inj_done_t = (c == 1) || (c == 5);
        end
        inj_done_t = 1'b0;
        n_chk++; if (n_ack !== 1 || ack_c !== 6) begin n_fail++; $display("FAIL spur_ack: count=%0d cycle=%0d want 1/6", n_ack, ack_c); end
        n_chk++; if (ack_v !== 4'b1000 || err_v !== 4'b0 || res_v !== 163'h55) begin n_fail++; $display("FAIL spur_result: ack=%b err=%b res=%h want 1000/0000/55", ack_v, err_v, res_v); end
        do_reset();
        set_op(1, 163'd1, 163'd1);
        mul_res_t = 163'hBEEF;
        req = 4'b0010;
        ack_c = -1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (mul_abort_t) n_abort++;
            if (ack_t != 4'b0 && ack_c < 0) begin ack_c = c; ack_v = ack_t; err_v = err_t; res_v = res_t; req = '0; end
            inj_done_t = (c == 17);
        end
        inj_done_t = 1'b0;
        n_chk++; if (ack_c !== 18 || ack_v !== 4'b0010) begin n_fail++; $display("FAIL tie_ack: cycle=%0d ack=%b want 18/0010", ack_c, ack_v); end
        n_chk++; if (err_v !== 4'b0 || res_v !== 163'hBEEF || n_abort !== 0) begin n_fail++; $display("FAIL tie_done_wins: err=%b res=%h aborts=%0d want 0000/beef/0", err_v, res_v, n_abort); end
    endtask

    task automatic test_reset_mid();
        int n_abort;
        n_abort = 0;
        do_reset();
        lat = 163;
        set_op(0, 163'd1, 163'd1);
        set_op(1, 163'd1, 163'd1);
        req = 4'b0001;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mul_abort) n_abort++;
            if (c == 5) begin
                n_chk++; if (ack !== 4'b0 || err !== 4'b0 || res !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_outputs: ack=%b err=%b busy=%b want 0", ack, err, busy); end
                n_chk++; if (grant_id !== 2'd0 || mul_start !== 1'b0 || mul_a !== '0 || mul_b !== '0) begin n_fail++; $display("FAIL rmid_regs: grant=%0d start=%b a=%h want 0", grant_id, mul_start, mul_a); end
                n_chk++; if (dut.r_ptr !== 2'd0) begin n_fail++; $display("FAIL rmid_ptr: got %0d want 0", dut.r_ptr); end
                rst = 1'b0;
            end
            if (c == 6) begin
                n_chk++; if (mul_start !== 1'b1 || grant_id !== 2'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL rmid_regrant: start=%b grant=%0d busy=%b want 1/0/1", mul_start, grant_id, busy); end
            end
            if (c == 3) req = 4'b0011;
            if (c == 4) rst = 1'b1;
        end
        n_chk++; if (n_abort !== 0) begin n_fail++; $display("FAIL rmid_no_abort: got %0d pulses want 0", n_abort); end
        do_reset();
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1, "time budget exceeded");
    end

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_back_to_back();
        test_timeout();
        test_spurious_done();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
